// File: rtl/fifo_param.sv
// Parametrised synchronous show-ahead FIFO with occupancy count, programmable
// almost flags and optional sticky error flags (enable with FIFO_PARAM_ERR_FLAGS_EN).
module fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       re,
  output logic [DATA_W-1:0]          rdata,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr_reg, rptr_reg;
  logic [CW-1:0]     count_reg, count_next;
  logic              empty_reg, full_reg, aempty_reg, afull_reg;
  logic              wa, ra;

  // A write while full is still accepted when a read frees the head slot.
  assign wa = we & (~full_reg | re);
  assign ra = re & ~empty_reg;

  always_comb begin
    count_next = count_reg;
    case ({wa, ra})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_reg   <= '0;
      rptr_reg   <= '0;
      count_reg  <= '0;
      empty_reg  <= 1'b1;
      full_reg   <= 1'b0;
      aempty_reg <= 1'b1;
      afull_reg  <= (AFULL_TH == 0);
    end else begin
      if (wa) wptr_reg <= wptr_reg + AW'(1);
      if (ra) rptr_reg <= rptr_reg + AW'(1);
      count_reg  <= count_next;
      empty_reg  <= (count_next == '0);
      full_reg   <= (count_next == DEPTH_C);
      aempty_reg <= (count_next <= AEMPTY_C);
      afull_reg  <= (count_next >= AFULL_C);
    end
  end

  // Storage is deliberately not reset; stale words are unreachable via the pointers.
  always_ff @(posedge clk) begin
    if (!reset && wa) mem[wptr_reg] <= wdata;
  end

  assign rdata        = mem[rptr_reg];
  assign empty        = empty_reg;
  assign full         = full_reg;
  assign almost_empty = aempty_reg;
  assign almost_full  = afull_reg;
  assign count        = count_reg;

`ifdef FIFO_PARAM_ERR_FLAGS_EN
  logic overflow_reg, underflow_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (we & full_reg & ~re) overflow_reg  <= 1'b1;
      if (re & empty_reg)      underflow_reg <= 1'b1;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param (DEPTH=8, AFULL_TH=6, AEMPTY_TH=2): a vector
// table for fill/overflow/drain/underflow plus hand sequences for corner cases.
module tb_fifo_param;

`ifdef FIFO_PARAM_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, we, re;
  logic [7:0] wdata, rdata;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [3:0] count;

  int tests = 0;
  int fails = 0;

  fifo_param #(.DATA_W(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2)) dut (
    .clk(clk), .reset(reset), .we(we), .wdata(wdata), .re(re), .rdata(rdata),
    .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic       re;
    logic [7:0] wdata;
    logic [3:0] cnt;
    logic [7:0] rd;
    logic       chk_rd;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Status flags are checked against what the occupancy alone implies.
  task automatic chk_status(input string tag, input logic [3:0] cnt,
                            input logic ovf, input logic udf);
    chk({tag, "/count"},        32'(count),        32'(cnt));
    chk({tag, "/empty"},        32'(empty),        32'(cnt == 4'd0));
    chk({tag, "/full"},         32'(full),         32'(cnt == 4'd8));
    chk({tag, "/almost_empty"}, 32'(almost_empty), 32'(cnt <= 4'd2));
    chk({tag, "/almost_full"},  32'(almost_full),  32'(cnt >= 4'd6));
    chk({tag, "/overflow"},     32'(overflow),     32'(ovf));
    chk({tag, "/underflow"},    32'(underflow),    32'(udf));
  endtask

  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    we = w; re = r; wdata = d;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic add(input logic w, input logic r, input logic [7:0] d,
                     input logic [3:0] c, input logic [7:0] rd, input logic crd,
                     input logic ovf, input logic udf);
    vec_t v;
    v.we = w; v.re = r; v.wdata = d; v.cnt = c; v.rd = rd; v.chk_rd = crd;
    v.ovf = ovf; v.udf = udf;
    vecs.push_back(v);
  endtask

  logic [7:0] model[$];
  logic [7:0] nxt;

  initial begin
    // Fill 0x10..0x17, overflow attempt, drain, then read while empty.
    for (int i = 0; i < 8; i++)
      add(1'b1, 1'b0, 8'(8'h10 + i), 4'(i + 1), 8'h10, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'hFF, 4'd8, 8'h10, 1'b1, ERR_EN, 1'b0);
    for (int j = 1; j <= 8; j++)
      add(1'b0, 1'b1, 8'h00, 4'(8 - j), 8'(8'h10 + j), j < 8, ERR_EN, 1'b0);
    add(1'b0, 1'b1, 8'h00, 4'd0, 8'h00, 1'b0, ERR_EN, ERR_EN);

    reset = 1'b1; we = 1'b0; re = 1'b0; wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_status("reset", 4'd0, 1'b0, 1'b0);

    foreach (vecs[k]) begin
      cycle(vecs[k].we, vecs[k].re, vecs[k].wdata);
      chk_status($sformatf("vec%0d", k), vecs[k].cnt, vecs[k].ovf, vecs[k].udf);
      if (vecs[k].chk_rd) chk($sformatf("vec%0d/rdata", k), 32'(rdata), 32'(vecs[k].rd));
      $display("[TB] vec %0d we=%0b re=%0b wdata=%02h count=%0d rdata=%02h",
               k, vecs[k].we, vecs[k].re, vecs[k].wdata, count, rdata);
    end

    // Reset clears sticky flags; then simultaneous write/read on empty.
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    cycle(1'b1, 1'b1, 8'h55);
    chk_status("wr_rd_empty", 4'd1, 1'b0, ERR_EN);
    chk("wr_rd_empty/rdata", 32'(rdata), 32'h55);
    $display("[TB] we+re on empty: count=%0d rdata=%02h underflow=%0b", count, rdata, underflow);

    // Fill to 8 behind 0x55, then simultaneous write/read while full.
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i));
    chk_status("refill", 4'd8, 1'b0, ERR_EN);
    chk("full_rw/rdata_before", 32'(rdata), 32'h55);
    cycle(1'b1, 1'b1, 8'hAA);
    chk_status("full_rw", 4'd8, 1'b0, ERR_EN);
    $display("[TB] we+re on full: count=%0d full=%0b rdata=%02h", count, full, rdata);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("full_drain%0d", i), 32'(rdata), (i < 7) ? 32'(8'h60 + i) : 32'hAA);
      cycle(1'b0, 1'b1, 8'h00);
    end
    chk_status("full_drained", 4'd0, 1'b0, ERR_EN);

    // Wrap: hold occupancy at 3 across many pointer wraps.
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    nxt = 8'h80;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, nxt); model.push_back(nxt); nxt++;
    end
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("wrap%0d/rdata", i), 32'(rdata), 32'(model[0]));
      cycle(1'b1, 1'b1, nxt);
      void'(model.pop_front()); model.push_back(nxt); nxt++;
      chk($sformatf("wrap%0d/count", i), 32'(count), 32'd3);
      $display("[TB] wrap %0d count=%0d head=%02h", i, count, rdata);
    end

    // Reset mid-operation at count 5 with a write pending in the same cycle.
    cycle(1'b1, 1'b0, nxt);
    cycle(1'b1, 1'b0, 8'(nxt + 1));
    chk("pre_reset/count", 32'(count), 32'd5);
    reset = 1'b1; we = 1'b1; wdata = 8'hEE;
    @(posedge clk); #1;
    reset = 1'b0; we = 1'b0;
    chk_status("mid_reset", 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h3C);
    chk_status("post_reset_wr", 4'd1, 1'b0, 1'b0);
    chk("post_reset_wr/rdata", 32'(rdata), 32'h3C);
    $display("[TB] after mid reset write: count=%0d rdata=%02h", count, rdata);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
